// File: rtl/packet_decoder_if.sv
// ULPI RX byte stream into the USB packet decoder, and the decoded events and
// DATAx payload stream coming back out of it.
interface packet_decoder_if;
  logic        rx_tvalid_i;
  logic        rx_tlast_i;
  logic        rx_error_i;
  logic [7:0]  rx_tdata_i;

  logic [3:0]  usb_pid_o;
  logic        tok_recv_o;
  logic        tok_ping_o;
  logic        sof_recv_o;
  logic        hsk_recv_o;
  logic        usb_recv_o;
  logic [6:0]  tok_addr_o;
  logic [3:0]  tok_endp_o;
  logic [10:0] frame_o;
  logic        eop_recv_o;
  logic        crc_error_o;
  logic        crc_valid_o;
  logic        dec_idle_o;
  logic        m_tvalid_o;
  logic        m_tlast_o;
  logic [7:0]  m_tdata_o;

  modport master (
    output rx_tvalid_i, rx_tlast_i, rx_error_i, rx_tdata_i,
    input  usb_pid_o, tok_recv_o, tok_ping_o, sof_recv_o, hsk_recv_o, usb_recv_o,
           tok_addr_o, tok_endp_o, frame_o, eop_recv_o, crc_error_o, crc_valid_o,
           dec_idle_o, m_tvalid_o, m_tlast_o, m_tdata_o
  );

  modport slave (
    input  rx_tvalid_i, rx_tlast_i, rx_error_i, rx_tdata_i,
    output usb_pid_o, tok_recv_o, tok_ping_o, sof_recv_o, hsk_recv_o, usb_recv_o,
           tok_addr_o, tok_endp_o, frame_o, eop_recv_o, crc_error_o, crc_valid_o,
           dec_idle_o, m_tvalid_o, m_tlast_o, m_tdata_o
  );
endinterface

// File: rtl/packet_decoder.sv
// USB packet decoder: PID/token/handshake decode with CRC5, DATAx payload
// streaming with CRC16 check and CRC bytes stripped via a 2-byte delay line.
module packet_decoder #(
  parameter int MAX_PAYLOAD = 1024
) (
  input logic             clock,
  input logic             reset,
  packet_decoder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, TOK1, TOK2, DATA, DROP} state_t;

  localparam logic [10:0] LEN_MAX   = 11'(MAX_PAYLOAD + 2);
  localparam logic [4:0]  CRC5_RES  = 5'b01100;
  localparam logic [15:0] CRC16_RES = 16'hB001;

  // Residual over the 11 field bits plus the 5 transmitted CRC bits, wire order.
  function automatic logic [4:0] crc5_res(input logic [15:0] bits);
    logic [4:0] c;
    logic       fb;
    c = 5'h1F;
    for (int i = 0; i < 16; i++) begin
      fb = c[4] ^ bits[i];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++)
      c = (c >> 1) ^ ((c[0] ^ d[i]) ? 16'hA001 : 16'h0000);
    return c;
  endfunction

  state_t      state, state_nx;
  logic [3:0]  pid_q, pid_nx, tpid_q, tpid_nx;
  logic [7:0]  b1_q, b1_nx;
  logic [6:0]  addr_q, addr_nx;
  logic [3:0]  endp_q, endp_nx;
  logic [10:0] frame_q, frame_nx;
  logic [10:0] cnt_q, cnt_nx;
  logic [15:0] crc_q, crc_nx;
  logic [7:0]  buf0_q, buf0_nx, buf1_q, buf1_nx;
  logic        drop_q, drop_nx;
  logic        tok_q, tok_nx, ping_q, ping_nx, sof_q, sof_nx, hsk_q, hsk_nx, usb_q, usb_nx;
  logic        eop_q, eop_nx, cerr_q, cerr_nx, cval_q, cval_nx;
  logic        mv_q, mv_nx, ml_q, ml_nx;
  logic [7:0]  md_q, md_nx;

  logic        v, last, err;
  logic [7:0]  din;
  logic [3:0]  pid;
  logic        pid_ok, is_tok, is_hsk, is_data;
  logic [10:0] cnt_inc;
  logic [15:0] crc_b;
  logic        len_ok;

  assign v       = bus.rx_tvalid_i;
  assign last    = bus.rx_tlast_i;
  assign err     = bus.rx_error_i;
  assign din     = bus.rx_tdata_i;
  assign pid     = din[3:0];
  assign pid_ok  = (din[7:4] == ~din[3:0]);
  assign is_tok  = (pid == 4'h1) || (pid == 4'h9) || (pid == 4'hD) || (pid == 4'h4) || (pid == 4'h5);
  assign is_hsk  = (pid == 4'h2) || (pid == 4'hA) || (pid == 4'hE) || (pid == 4'h6);
  assign is_data = (pid == 4'h3) || (pid == 4'hB) || (pid == 4'h7) || (pid == 4'hF);
  assign cnt_inc = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
  assign crc_b   = crc16_byte(crc_q, din);
  assign len_ok  = (cnt_inc >= 11'd2) && (cnt_inc <= LEN_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pid_nx   = pid_q;   tpid_nx  = tpid_q;  b1_nx   = b1_q;
    addr_nx  = addr_q;  endp_nx  = endp_q;  frame_nx = frame_q;
    cnt_nx   = cnt_q;   crc_nx   = crc_q;
    buf0_nx  = buf0_q;  buf1_nx  = buf1_q;  drop_nx = drop_q;
    tok_nx   = 1'b0;    ping_nx  = 1'b0;    sof_nx  = 1'b0;
    hsk_nx   = 1'b0;    usb_nx   = 1'b0;    eop_nx  = 1'b0;
    cerr_nx  = 1'b0;    cval_nx  = 1'b0;
    mv_nx    = 1'b0;    ml_nx    = 1'b0;    md_nx   = md_q;

    case (state)
      IDLE: if (v) begin
        drop_nx = 1'b0;
        if (!pid_ok) begin
          state_nx = last ? IDLE : DROP;
        end else begin
          pid_nx = pid;
          if (is_tok) begin
            tpid_nx  = pid;
            state_nx = last ? IDLE : TOK1;
          end else if (is_hsk) begin
            if (last) hsk_nx = 1'b1;
            else      state_nx = DROP;
          end else if (is_data) begin
            usb_nx  = 1'b1;
            cnt_nx  = '0;
            crc_nx  = 16'hFFFF;
            buf0_nx = '0;
            buf1_nx = '0;
            // A PID-only DATAx packet is too short to carry its CRC.
            if (last) cerr_nx = 1'b1;
            else      state_nx = DATA;
          end else begin
            state_nx = last ? IDLE : DROP;
          end
        end
      end

      TOK1: begin
        if (err)           state_nx = (v && last) ? IDLE : DROP;
        else if (v && last) state_nx = IDLE;
        else if (v) begin
          b1_nx    = din;
          state_nx = TOK2;
        end
      end

      TOK2: begin
        if (err)      state_nx = (v && last) ? IDLE : DROP;
        else if (v && !last) state_nx = DROP;
        else if (v) begin
          state_nx = IDLE;
          if (crc5_res({din, b1_q}) == CRC5_RES) begin
            addr_nx  = b1_q[6:0];
            endp_nx  = {din[2:0], b1_q[7]};
            frame_nx = {din[2:0], b1_q};
            if (tpid_q == 4'h5) sof_nx = 1'b1;
            else begin
              tok_nx  = 1'b1;
              ping_nx = (tpid_q == 4'h4);
            end
          end
        end
      end

      DATA: begin
        if (err) begin
          if (v && last) begin
            cerr_nx  = 1'b1;
            state_nx = IDLE;
          end else begin
            drop_nx  = 1'b1;
            state_nx = DROP;
          end
        end else if (v) begin
          cnt_nx  = cnt_inc;
          crc_nx  = crc_b;
          buf0_nx = buf1_q;
          buf1_nx = din;
          // The two most recent bytes may be CRC, so only the oldest is released.
          if (cnt_q >= 11'd2 && cnt_q < LEN_MAX) begin
            mv_nx = 1'b1;
            md_nx = buf0_q;
            ml_nx = last;
          end
          if (last) begin
            state_nx = IDLE;
            if (crc_b == CRC16_RES && len_ok) begin
              eop_nx  = 1'b1;
              cval_nx = 1'b1;
            end else begin
              cerr_nx = 1'b1;
            end
          end
        end
      end

      DROP: if (v && last) begin
        state_nx = IDLE;
        cerr_nx  = drop_q;
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pid_q  <= '0; tpid_q <= '0; b1_q    <= '0;
      addr_q <= '0; endp_q <= '0; frame_q <= '0;
      cnt_q  <= '0; crc_q  <= 16'hFFFF;
      buf0_q <= '0; buf1_q <= '0; drop_q  <= 1'b0;
      tok_q  <= 1'b0; ping_q <= 1'b0; sof_q <= 1'b0; hsk_q <= 1'b0; usb_q <= 1'b0;
      eop_q  <= 1'b0; cerr_q <= 1'b0; cval_q <= 1'b0;
      mv_q   <= 1'b0; ml_q   <= 1'b0; md_q  <= '0;
    end else begin
      pid_q  <= pid_nx;  tpid_q <= tpid_nx; b1_q    <= b1_nx;
      addr_q <= addr_nx; endp_q <= endp_nx; frame_q <= frame_nx;
      cnt_q  <= cnt_nx;  crc_q  <= crc_nx;
      buf0_q <= buf0_nx; buf1_q <= buf1_nx; drop_q  <= drop_nx;
      tok_q  <= tok_nx;  ping_q <= ping_nx; sof_q <= sof_nx; hsk_q <= hsk_nx; usb_q <= usb_nx;
      eop_q  <= eop_nx;  cerr_q <= cerr_nx; cval_q <= cval_nx;
      mv_q   <= mv_nx;   ml_q   <= ml_nx;   md_q  <= md_nx;
    end
  end

  assign bus.usb_pid_o   = pid_q;
  assign bus.tok_recv_o  = tok_q;
  assign bus.tok_ping_o  = ping_q;
  assign bus.sof_recv_o  = sof_q;
  assign bus.hsk_recv_o  = hsk_q;
  assign bus.usb_recv_o  = usb_q;
  assign bus.tok_addr_o  = addr_q;
  assign bus.tok_endp_o  = endp_q;
  assign bus.frame_o     = frame_q;
  assign bus.eop_recv_o  = eop_q;
  assign bus.crc_error_o = cerr_q;
  assign bus.crc_valid_o = cval_q;
  assign bus.dec_idle_o  = (state == IDLE);
  assign bus.m_tvalid_o  = mv_q;
  assign bus.m_tlast_o   = ml_q;
  assign bus.m_tdata_o   = md_q;

endmodule

// File: tb/tb_packet_decoder.sv
// Scoreboard bench for packet_decoder: expected events and payload beats are
// queued as packets are driven and matched against DUT outputs at negedge.
module tb_packet_decoder;
  localparam int MAXP = 16;

  localparam logic [7:0] EV_TOK  = 8'h80;
  localparam logic [7:0] EV_PING = 8'hC0;
  localparam logic [7:0] EV_SOF  = 8'h20;
  localparam logic [7:0] EV_HSK  = 8'h10;
  localparam logic [7:0] EV_USB  = 8'h08;
  localparam logic [7:0] EV_EOP  = 8'h06;
  localparam logic [7:0] EV_CERR = 8'h01;

  typedef struct {
    logic [7:0]  code;
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [10:0] frame;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  packet_decoder_if bus();
  packet_decoder #(.MAX_PAYLOAD(MAXP)) dut (.clock(clock), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  ev_t        exq[$];
  logic [8:0] bq[$];
  logic [7:0] pkt[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_ev(input logic [7:0] code, input logic [3:0] pid,
                         input logic [6:0] addr, input logic [3:0] endp, input logic [10:0] frame);
    ev_t e;
    e.code = code; e.pid = pid; e.addr = addr; e.endp = endp; e.frame = frame;
    exq.push_back(e);
  endtask

  // CRC5 field generator: complemented remainder sent MSB first in b2[7:3].
  function automatic logic [7:0] tok_b2(input logic [10:0] d);
    logic [4:0] c;
    logic       fb;
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb = c[4] ^ d[i];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    c = ~c;
    return {c[0], c[1], c[2], c[3], c[4], d[10:8]};
  endfunction

  function automatic logic [15:0] crc16_q(input int n);
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'hFFFF;
    for (int k = 1; k <= n; k++) begin
      b = pkt[k];
      for (int i = 0; i < 8; i++) begin
        if (c[0] ^ b[i]) c = (c >> 1) ^ 16'hA001;
        else             c = c >> 1;
      end
    end
    return c;
  endfunction

  task automatic drive(input logic [7:0] b, input logic last, input logic err);
    @(negedge clock);
    bus.rx_tvalid_i = 1'b1;
    bus.rx_tdata_i  = b;
    bus.rx_tlast_i  = last;
    bus.rx_error_i  = err;
  endtask

  task automatic idle_in();
    bus.rx_tvalid_i = 1'b0;
    bus.rx_tlast_i  = 1'b0;
    bus.rx_error_i  = 1'b0;
  endtask

  task automatic send_pkt(input int err_at, input bit gaps);
    for (int i = 0; i < pkt.size(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        @(negedge clock);
        idle_in();
      end
      drive(pkt[i], i == pkt.size() - 1, i == err_at);
    end
    @(negedge clock);
    idle_in();
    repeat (3) @(negedge clock);
  endtask

  task automatic send_tok(input logic [3:0] pid, input logic [10:0] d, input bit gaps);
    pkt = {};
    pkt.push_back({~pid, pid});
    pkt.push_back(d[7:0]);
    pkt.push_back(tok_b2(d));
    send_pkt(-1, gaps);
  endtask

  // Builds a DATAx packet in pkt; when push is set, queues the spec-derived outcome.
  task automatic mk_data(input logic [3:0] pid, input int n, input bit flip, input bit push);
    logic [15:0] c;
    pkt = {};
    pkt.push_back({~pid, pid});
    for (int i = 0; i < n; i++) pkt.push_back(8'($urandom_range(0, 255)));
    c = ~crc16_q(n);
    pkt.push_back(c[7:0]);
    pkt.push_back(c[15:8] ^ (flip ? 8'h01 : 8'h00));
    if (push) begin
      push_ev(EV_USB, pid, 0, 0, 0);
      for (int i = 0; i < n && i < MAXP; i++)
        bq.push_back({(i == n - 1) && (n <= MAXP), pkt[i + 1]});
      push_ev((!flip && n <= MAXP) ? EV_EOP : EV_CERR, pid, 0, 0, 0);
    end
  endtask

  logic [7:0] code;
  ev_t        e;
  always @(negedge clock) begin
    if (reset) begin
      code = {bus.tok_recv_o, bus.tok_ping_o, bus.sof_recv_o, bus.hsk_recv_o,
              bus.usb_recv_o, bus.eop_recv_o, bus.crc_valid_o, bus.crc_error_o};
      if (code != 8'h00) begin
        chk("excl", 32'($countones({bus.tok_recv_o, bus.sof_recv_o, bus.hsk_recv_o,
                                    bus.eop_recv_o, bus.crc_error_o}) <= 1), 1);
        if (exq.size() == 0) chk("unexp_evt", {24'h0, code}, 0);
        else begin
          e = exq.pop_front();
          chk("evt_code", {24'h0, code}, {24'h0, e.code});
          if (e.code[7] || e.code[5] || e.code[4] || e.code[3])
            chk("evt_pid", bus.usb_pid_o, e.pid);
          if (e.code[7]) begin
            chk("tok_addr", bus.tok_addr_o, e.addr);
            chk("tok_endp", bus.tok_endp_o, e.endp);
          end
          if (e.code[5]) chk("sof_frame", bus.frame_o, e.frame);
        end
      end
      if (bus.m_tvalid_o) begin
        if (bq.size() == 0) chk("unexp_beat", {23'h0, 1'b1, bus.m_tlast_o, bus.m_tdata_o}, 0);
        else chk("beat", {bus.m_tlast_o, bus.m_tdata_o}, bq.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_in();
    bus.rx_tdata_i = 8'h00;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_idle", bus.dec_idle_o, 1);
    chk("rst_pid", bus.usb_pid_o, 0);
    chk("rst_addr", bus.tok_addr_o, 0);
    chk("rst_endp", bus.tok_endp_o, 0);
    chk("rst_frame", bus.frame_o, 0);
    chk("rst_mvalid", bus.m_tvalid_o, 0);
    chk("rst_mdata", bus.m_tdata_o, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // SETUP addr 0 endp 0 with its fixed CRC5 bytes
    pkt = {8'h2D, 8'h00, 8'h10};
    push_ev(EV_TOK, 4'hD, 7'h00, 4'h0, 0);
    send_pkt(-1, 0);

    // corrupted CRC5: silent return to IDLE
    pkt = {8'h69, 8'h00, 8'h11};
    for (int i = 0; i < 3; i++) drive(pkt[i], i == 2, 1'b0);
    @(negedge clock);
    idle_in();
    chk("crc5_bad_idle", bus.dec_idle_o, 1);
    repeat (2) @(negedge clock);

    pkt = {8'hD2};
    push_ev(EV_HSK, 4'h2, 0, 0, 0);
    send_pkt(-1, 0);
    pkt = {8'hD3};
    send_pkt(-1, 0);
    chk("pid_held", bus.usb_pid_o, 4'h2);

    // token PID with tlast in TOK1: no pulse
    pkt = {8'hE1, 8'h05};
    send_pkt(-1, 0);

    push_ev(EV_PING, 4'h4, 7'h55, 4'hA, 0);
    send_tok(4'h4, {4'hA, 7'h55}, 0);
    push_ev(EV_TOK, 4'h1, 7'h7F, 4'hF, 0);
    send_tok(4'h1, {4'hF, 7'h7F}, 1);
    push_ev(EV_SOF, 4'h5, 0, 0, 11'h5A3);
    send_tok(4'h5, 11'h5A3, 0);

    // zero-length DATA0 with the spec's literal CRC bytes
    pkt = {8'hC3, 8'h00, 8'h00};
    push_ev(EV_USB, 4'h3, 0, 0, 0);
    push_ev(EV_EOP, 4'h3, 0, 0, 0);
    send_pkt(-1, 0);

    mk_data(4'hB, 4, 0, 1);  send_pkt(-1, 0);
    mk_data(4'hB, 4, 1, 1);  send_pkt(-1, 0);
    mk_data(4'h7, 1, 0, 1);  send_pkt(-1, 1);
    mk_data(4'hF, MAXP, 0, 1);     send_pkt(-1, 0);
    mk_data(4'h3, MAXP + 1, 0, 1); send_pkt(-1, 0);
    for (int k = 0; k < 4; k++) begin
      mk_data(4'h3, $urandom_range(2, 12), 0, 1);
      send_pkt(-1, 1);
    end

    // DATA0 with only one post-PID byte: too short
    pkt = {8'hC3, 8'h5A};
    push_ev(EV_USB, 4'h3, 0, 0, 0);
    push_ev(EV_CERR, 4'h3, 0, 0, 0);
    send_pkt(-1, 0);

    // rx_error on payload byte 2
    mk_data(4'hB, 4, 0, 0);
    push_ev(EV_USB, 4'hB, 0, 0, 0);
    push_ev(EV_CERR, 4'hB, 0, 0, 0);
    send_pkt(2, 0);
    push_ev(EV_TOK, 4'h9, 7'h00, 4'h0, 0);
    pkt = {8'h69, 8'h00, 8'h10};
    send_pkt(-1, 0);

    // reset mid-DATA abandons the packet
    push_ev(EV_USB, 4'h3, 0, 0, 0);
    drive(8'hC3, 1'b0, 1'b0);
    drive(8'h11, 1'b0, 1'b0);
    drive(8'h22, 1'b0, 1'b0);
    @(negedge clock);
    idle_in();
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_idle", bus.dec_idle_o, 1);
    chk("midrst_pid", bus.usb_pid_o, 0);
    chk("midrst_mvalid", bus.m_tvalid_o, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    pkt = {8'h33, 8'h44, 8'h55};
    send_pkt(-1, 0);
    push_ev(EV_TOK, 4'h9, 7'h00, 4'h0, 0);
    pkt = {8'h69, 8'h00, 8'h10};
    send_pkt(-1, 0);

    repeat (5) @(negedge clock);
    chk("evq_empty", exq.size(), 0);
    chk("beatq_empty", bq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
